// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing single-outstanding imem requests into a small {pc+4, inst} queue.
// Optional FETCH_STATS_EN adds stat_fetched/stat_dropped counters.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_pc4,
  output logic [31:0] out_inst
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_dropped
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  state_t state, state_nx;
  logic [31:0] fetch_pc, drop_addr;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [31:0] q_pc4 [DEPTH];
  logic [31:0] q_inst [DEPTH];
  logic push, pop, discard;
  always_comb begin
    imem_req = ~rst & (state != IDLE | ((count < FULL) & ~redirect));
    imem_addr = state == DROP ? drop_addr : fetch_pc;
    push = imem_ack & imem_req & ~redirect & state != DROP;
    discard = imem_ack & imem_req & (state == DROP | redirect);
    state_nx = imem_ack ? IDLE : (state == IDLE & imem_req) ? WAIT : (state == WAIT & redirect) ? DROP : state;
  end
  assign out_valid = count != '0;
  assign out_pc4 = q_pc4[rd_ptr];
  assign out_inst = q_inst[rd_ptr];
  assign pop = out_valid & ~stall & ~redirect;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      fetch_pc <= RESET_PC & ~32'd3;
      drop_addr <= RESET_PC & ~32'd3;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc4[i] <= '0;
        q_inst[i] <= '0;
      end
    end else begin
      state <= state_nx;
      // DROP keeps presenting the abandoned address while fetch_pc moves on
      if (state == WAIT & redirect & ~imem_ack) drop_addr <= fetch_pc;
      if (redirect) begin
        fetch_pc <= redirect_pc & ~32'd3;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count <= '0;
      end else begin
        if (push) begin
          q_pc4[wr_ptr] <= fetch_pc + 32'd4;
          q_inst[wr_ptr] <= imem_rdata;
          wr_ptr <= wr_ptr + 1'b1;
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
    end
  end
`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_fetched <= '0;
      stat_dropped <= '0;
    end else begin
      stat_fetched <= stat_fetched + 32'(push);
      stat_dropped <= stat_dropped + 32'(discard) + (redirect ? 32'(count) : 32'd0);
    end
  end
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized memory/pipeline stimulus checked against a queue-level fetch model.
module tb_fetch_unit;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 0;
  logic imem_req, imem_ack = 0;
  logic [31:0] imem_addr, imem_rdata = 0;
  logic redirect = 0, stall = 0;
  logic [31:0] redirect_pc = 0;
  logic out_valid;
  logic [31:0] out_pc4, out_inst;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_dropped;
`endif
  always #5 clk = ~clk;
  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .out_valid(out_valid), .out_pc4(out_pc4), .out_inst(out_inst)
`ifdef FETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_dropped(stat_dropped)
`endif
  );
  int checks = 0, fails = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction
  // reference model: expected queue contents, next fetch PC, one outstanding request
  logic [63:0] q[$];
  logic [31:0] pc = 0, busy_addr = 0;
  bit busy = 0, stale = 0;
  int unsigned fetched = 0, dropped = 0;
  // memory responder
  bit mbusy = 0;
  int mwait = 0, mlat = 0;
  task automatic step(input int p_stall, input int p_redir, input int max_lat, input logic [31:0] base);
    logic exp_req;
    logic [31:0] exp_addr;
    stall = $urandom_range(99) < p_stall;
    redirect = $urandom_range(99) < p_redir;
    redirect_pc = base + ($urandom & 32'hFF);
    #1;
    if (imem_req && !mbusy) begin
      mbusy = 1;
      mwait = 0;
      mlat = $urandom_range(max_lat);
    end
    imem_ack = mbusy && mwait == mlat;
    imem_rdata = imem_ack ? mem_data(imem_addr) : $urandom;
    #1;
    exp_req = busy || (q.size() < DEPTH && !redirect);
    exp_addr = busy ? busy_addr : pc;
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, exp_addr);
    check("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("out_pc4", out_pc4, q[0][63:32]);
      check("out_inst", out_inst, q[0][31:0]);
    end
`ifdef FETCH_STATS_EN
    check("stat_fetched", stat_fetched, fetched);
    check("stat_dropped", stat_dropped, dropped);
`endif
    if (!busy && exp_req) begin
      busy = 1;
      busy_addr = pc;
    end
    if (redirect) begin
      dropped += q.size() + (imem_ack ? 1 : 0);
      q.delete();
      pc = redirect_pc & ~32'd3;
      if (imem_ack) begin
        busy = 0;
        stale = 0;
      end else if (busy) stale = 1;
    end else begin
      if (q.size() != 0 && !stall) void'(q.pop_front());
      if (imem_ack) begin
        busy = 0;
        if (stale) begin
          dropped++;
          stale = 0;
        end else begin
          q.push_back({busy_addr + 32'd4, mem_data(busy_addr)});
          pc = busy_addr + 32'd4;
          fetched++;
        end
      end
    end
    @(posedge clk);
    if (imem_ack) mbusy = 0;
    else if (mbusy) mwait++;
    @(negedge clk);
  endtask
  initial begin
    #1 rst = 1;
    #2;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", out_valid, 0);
    check("rst_pc4", out_pc4, 0);
    check("rst_inst", out_inst, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    repeat (60) step(0, 0, 0, 0);
    repeat (60) step(0, 0, 3, 0);
    repeat (30) step(100, 0, 2, 0);
    repeat (40) step(0, 0, 1, 0);
    repeat (400) step(30, 8, 3, 32'h100);
    repeat (300) step(20, 10, 2, 32'hFFFF_FF00);
    repeat (200) step(10, 3, 0, 32'hFFFF_FFF0);
    // park the unit in WAIT, then reset asynchronously mid-cycle
    stall = 0;
    redirect = 0;
    imem_ack = 0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("pre_rst_req", imem_req, 1);
    #2 rst = 1;
    #1;
    check("arst_req", imem_req, 0);
    check("arst_addr", imem_addr, 32'h0);
    check("arst_valid", out_valid, 0);
    check("arst_pc4", out_pc4, 0);
    check("arst_inst", out_inst, 0);
`ifdef FETCH_STATS_EN
    check("arst_fetched", stat_fetched, 0);
    check("arst_dropped", stat_dropped, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
